// File: rtl/period_to_frequency.sv
// Converts a reciprocal-counter period count into a frequency word:
// freq = CLK_FREQ * Ncycles * 2^FRAC_BITS / count, one quotient bit per clock.
module period_to_frequency #(
  parameter int unsigned CLK_FREQ         = 125000000,
  parameter int unsigned COUNT_WIDTH      = 32,
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned FRAC_BITS        = 0,
  parameter int unsigned DIV_WIDTH        = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [COUNT_WIDTH-1:0]      count_in,
  input  logic [COUNT_WIDTH-1:0]      Ncycles,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_OUT_tdata,
  output logic                        M_AXIS_OUT_tvalid,
  input  logic                        M_AXIS_OUT_tready,
  output logic                        saturated,
  output logic                        busy
);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    OUT
  } state_t;

  localparam int unsigned ITER_W = $clog2(DIV_WIDTH + 1);
  localparam logic [DIV_WIDTH-1:0] CLK_FREQ_W = DIV_WIDTH'(CLK_FREQ);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(DIV_WIDTH);

  // Numerator wraps modulo 2^DIV_WIDTH by construction of the operand widths.
  function automatic logic [DIV_WIDTH-1:0] numerator(input logic [COUNT_WIDTH-1:0] ncyc);
    logic [DIV_WIDTH-1:0] prod;
    prod = CLK_FREQ_W * DIV_WIDTH'(ncyc);
    return prod << FRAC_BITS;
  endfunction

  state_t                      state_q, state_d;
  logic [COUNT_WIDTH-1:0]      count_prev_q, count_prev_d;
  logic                        pend_q, pend_d;
  logic [COUNT_WIDTH-1:0]      pend_count_q, pend_count_d;
  logic [COUNT_WIDTH-1:0]      pend_ncyc_q, pend_ncyc_d;
  logic [COUNT_WIDTH-1:0]      divisor_q, divisor_d;
  logic [COUNT_WIDTH-1:0]      rem_q, rem_d;
  logic [DIV_WIDTH-1:0]        quo_q, quo_d;
  logic [ITER_W-1:0]           iter_q, iter_d;
  logic [AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                        sat_q, sat_d;

  logic                        new_meas;
  logic                        ld_en;
  logic [COUNT_WIDTH-1:0]      ld_count;
  logic [COUNT_WIDTH-1:0]      ld_ncyc;
  logic [COUNT_WIDTH:0]        rem_shift;
  logic [COUNT_WIDTH:0]        rem_diff;
  logic                        q_bit;
  logic                        quo_overflow;

  // A zero count never triggers, which doubles as the divide-by-zero guard.
  assign new_meas = (count_in != count_prev_q) && (count_in != '0);

  // Quotient bits shift in from the bottom while numerator bits leave the top,
  // so one register serves as both numerator and quotient.
  assign rem_shift    = {rem_q, quo_q[DIV_WIDTH-1]};
  assign rem_diff     = rem_shift - {1'b0, divisor_q};
  assign q_bit        = (rem_shift >= {1'b0, divisor_q});
  assign quo_overflow = |quo_q[DIV_WIDTH-1:AXIS_TDATA_WIDTH];

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d      = state_q;
    count_prev_d = count_in;
    pend_d       = pend_q;
    pend_count_d = pend_count_q;
    pend_ncyc_d  = pend_ncyc_q;
    divisor_d    = divisor_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    iter_d       = iter_q;
    tdata_d      = tdata_q;
    sat_d        = sat_q;
    ld_en        = 1'b0;
    ld_count     = count_in;
    ld_ncyc      = Ncycles;

    unique case (state_q)
      IDLE: begin
        if (new_meas) begin
          ld_en   = 1'b1;
          state_d = DIV;
        end
      end

      DIV: begin
        if (new_meas) begin
          pend_d       = 1'b1;
          pend_count_d = count_in;
          pend_ncyc_d  = Ncycles;
        end
        if (iter_q == LAST_ITER) begin
          sat_d   = quo_overflow;
          tdata_d = quo_overflow ? '1 : quo_q[AXIS_TDATA_WIDTH-1:0];
          state_d = OUT;
        end else begin
          rem_d  = q_bit ? rem_diff[COUNT_WIDTH-1:0] : rem_shift[COUNT_WIDTH-1:0];
          quo_d  = {quo_q[DIV_WIDTH-2:0], q_bit};
          iter_d = iter_q + ITER_W'(1);
        end
      end

      OUT: begin
        if (M_AXIS_OUT_tready) begin
          // A measurement arriving on the handshake edge is newer than the slot.
          if (new_meas) begin
            ld_en   = 1'b1;
            pend_d  = 1'b0;
            state_d = DIV;
          end else if (pend_q) begin
            ld_en    = 1'b1;
            ld_count = pend_count_q;
            ld_ncyc  = pend_ncyc_q;
            pend_d   = 1'b0;
            state_d  = DIV;
          end else begin
            state_d = IDLE;
          end
        end else if (new_meas) begin
          pend_d       = 1'b1;
          pend_count_d = count_in;
          pend_ncyc_d  = Ncycles;
        end
      end

      default: state_d = IDLE;
    endcase

    if (ld_en) begin
      divisor_d = ld_count;
      quo_d     = numerator(ld_ncyc);
      rem_d     = '0;
      iter_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= IDLE;
      count_prev_q <= '0;
      pend_q       <= 1'b0;
      pend_count_q <= '0;
      pend_ncyc_q  <= '0;
      divisor_q    <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      iter_q       <= '0;
      tdata_q      <= '0;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_prev_q <= count_prev_d;
      pend_q       <= pend_d;
      pend_count_q <= pend_count_d;
      pend_ncyc_q  <= pend_ncyc_d;
      divisor_q    <= divisor_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      iter_q       <= iter_d;
      tdata_q      <= tdata_d;
      sat_q        <= sat_d;
    end
  end

  assign M_AXIS_OUT_tdata  = tdata_q;
  assign M_AXIS_OUT_tvalid = (state_q == OUT);
  assign saturated         = sat_q;
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_period_to_frequency.sv
// Directed bench for period_to_frequency: a default instance and a FRAC_BITS=8
// instance, each with an expected-beat queue drained by a negedge monitor.
module tb_period_to_frequency;

  typedef struct packed {
    logic [31:0] data;
    logic        sat;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cnt_a = '0, ncy_a = '0, cnt_b = '0, ncy_b = '0;
  logic        rdy_a = 1'b1, rdy_b = 1'b1;
  logic [31:0] tdata_a, tdata_b;
  logic        tvalid_a, tvalid_b, sat_a, sat_b, busy_a, busy_b;

  int    total = 0;
  int    bad = 0;
  int    beats_a = 0;
  int    beats_b = 0;
  beat_t q_a[$];
  beat_t q_b[$];

  always #5 clk = ~clk;

  period_to_frequency dut_a (
    .clk(clk), .rst(rst), .count_in(cnt_a), .Ncycles(ncy_a),
    .M_AXIS_OUT_tdata(tdata_a), .M_AXIS_OUT_tvalid(tvalid_a),
    .M_AXIS_OUT_tready(rdy_a), .saturated(sat_a), .busy(busy_a)
  );

  period_to_frequency #(.FRAC_BITS(8)) dut_b (
    .clk(clk), .rst(rst), .count_in(cnt_b), .Ncycles(ncy_b),
    .M_AXIS_OUT_tdata(tdata_b), .M_AXIS_OUT_tvalid(tvalid_b),
    .M_AXIS_OUT_tready(rdy_b), .saturated(sat_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] d, input logic s);
    beat_t b;
    b.data = d;
    b.sat  = s;
    return b;
  endfunction

  // While a beat is expected, tdata/saturated must match the queue head on
  // every valid cycle; with nothing expected, tvalid must stay low.
  always @(negedge clk) begin
    if (!rst) begin
      if (q_a.size() == 0) begin
        check("a_spurious_tvalid", 64'(tvalid_a), 64'd0);
      end else if (tvalid_a) begin
        check("a_tdata", 64'(tdata_a), 64'(q_a[0].data));
        check("a_saturated", 64'(sat_a), 64'(q_a[0].sat));
        if (rdy_a) begin
          void'(q_a.pop_front());
          beats_a++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (q_b.size() == 0) begin
        check("b_spurious_tvalid", 64'(tvalid_b), 64'd0);
      end else if (tvalid_b) begin
        check("b_tdata", 64'(tdata_b), 64'(q_b[0].data));
        check("b_saturated", 64'(sat_b), 64'(q_b[0].sat));
        if (rdy_b) begin
          void'(q_b.pop_front());
          beats_b++;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called right after driving a new count; the next edge latches it.
  task automatic latency(input bit sel_b, input string tag);
    int   n = 0;
    logic v = 1'b0;
    @(posedge clk);
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      v = sel_b ? tvalid_b : tvalid_a;
      if (n == 1) check({tag, "_busy"}, 64'(sel_b ? busy_b : busy_a), 64'd1);
    end while (!v && n < 200);
    check(tag, 64'(n), 64'd65);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input bit sel_b, input int budget, input string tag);
    int n = 0;
    while ((sel_b ? q_b.size() : q_a.size()) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(tag, 64'(sel_b ? q_b.size() : q_a.size()), 64'd0);
  endtask

  initial begin
    int b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_tvalid", 64'(tvalid_a), 64'd0);
    check("rst_a_tdata", 64'(tdata_a), 64'd0);
    check("rst_a_sat", 64'(sat_a), 64'd0);
    check("rst_a_busy", 64'(busy_a), 64'd0);
    check("rst_b_tvalid", 64'(tvalid_b), 64'd0);
    check("rst_b_busy", 64'(busy_b), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // 125 MHz / 125000 ticks = 1000 Hz
    ncy_a = 32'd1;
    cnt_a = 32'd125000;
    q_a.push_back(mk(32'd1000, 1'b0));
    latency(1'b0, "a_lat_1000");
    wait_drain(1'b0, 50, "a_drain_1000");

    ncy_a = 32'd10;
    cnt_a = 32'd1250000;
    q_a.push_back(mk(32'd1000, 1'b0));
    latency(1'b0, "a_lat_n10");
    wait_drain(1'b0, 50, "a_drain_n10");

    // 125e6 / 3 truncates
    ncy_a = 32'd1;
    cnt_a = 32'd3;
    q_a.push_back(mk(32'd41666666, 1'b0));
    latency(1'b0, "a_lat_trunc");
    wait_drain(1'b0, 50, "a_drain_trunc");

    ncy_b = 32'd1;
    cnt_b = 32'd125000;
    q_b.push_back(mk(32'd256000, 1'b0));
    latency(1'b1, "b_lat_frac");
    wait_drain(1'b1, 50, "b_drain_frac");

    // 125e6 * 100 * 256 / 1 overflows 32 bits
    cnt_b = 32'd1;
    ncy_b = 32'd100;
    q_b.push_back(mk(32'hFFFF_FFFF, 1'b1));
    latency(1'b1, "b_lat_sat");
    wait_drain(1'b1, 50, "b_drain_sat");
    cnt_b = '0;
    idle(2);

    // Backpressure: 62500 is overwritten in the pending slot by 25000.
    b0 = beats_a;
    rdy_a = 1'b0;
    cnt_a = 32'd125000;
    q_a.push_back(mk(32'd1000, 1'b0));
    idle(30);
    cnt_a = 32'd62500;
    idle(100);
    cnt_a = 32'd25000;
    q_a.push_back(mk(32'd5000, 1'b0));
    idle(70);
    @(negedge clk);
    check("hold_tvalid", 64'(tvalid_a), 64'd1);
    check("hold_tdata", 64'(tdata_a), 64'd1000);
    @(posedge clk);
    #1;
    rdy_a = 1'b1;
    wait_drain(1'b0, 300, "bp_drain");
    idle(150);
    check("bp_beat_count", 64'(beats_a - b0), 64'd2);

    // Zero is ignored; a held count yields exactly one beat.
    b0 = beats_a;
    cnt_a = '0;
    idle(1);
    cnt_a = 32'd125000;
    q_a.push_back(mk(32'd1000, 1'b0));
    idle(500);
    check("hold_one_beat", 64'(beats_a - b0), 64'd1);
    check("hold_queue_empty", 64'(q_a.size()), 64'd0);

    // Reset on the edge that would run iteration 30 aborts the division.
    b0 = beats_a;
    cnt_a = '0;
    idle(1);
    cnt_a = 32'd125000;
    idle(1);
    repeat (29) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_tvalid", 64'(tvalid_a), 64'd0);
    check("abort_busy", 64'(busy_a), 64'd0);
    check("abort_tdata", 64'(tdata_a), 64'd0);
    rst = 1'b0;
    q_a.push_back(mk(32'd1000, 1'b0));
    latency(1'b0, "a_lat_after_rst");
    wait_drain(1'b0, 50, "a_drain_after_rst");
    idle(100);
    check("abort_beat_count", 64'(beats_a - b0), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/period_to_frequency.md
Name: period_to_frequency

Overview:
- Sits directly downstream of the reciprocal frequency counter. Consumes its latched period count (clock ticks spanning Ncycles signal periods) and converts it to frequency: freq = CLK_FREQ * Ncycles * 2^FRAC_BITS / count.
- Uses a sequential restoring divider, one quotient bit per clock.
- Result is emitted on an AXI-Stream master for the PS readout / DMA path.

Parameters:
- CLK_FREQ, 125000000, sampling clock frequency in Hz (numerator constant).
- COUNT_WIDTH, 32, width of period count and Ncycles inputs.
- AXIS_TDATA_WIDTH, 32, output frequency word width.
- FRAC_BITS, 0, fractional bits of the output (unsigned fixed point, Hz units).
- DIV_WIDTH, 64, internal numerator/quotient width; number of divider iterations.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous reset, active-high.
- count_in  in  COUNT_WIDTH  latched period count from the frequency counter.
- Ncycles  in  COUNT_WIDTH  cycle count used for that measurement.
- M_AXIS_OUT_tdata  out  AXIS_TDATA_WIDTH  frequency result.
- M_AXIS_OUT_tvalid  out  1  result valid.
- M_AXIS_OUT_tready  in  1  downstream ready.
- saturated  out  1  result clipped, qualified by tvalid.
- busy  out  1  high in DIV or OUT state.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; tdata=0; tvalid=0; saturated=0; busy=0; count_prev=0; pending flag=0; divider registers=0. Reset mid-division or mid-hold aborts silently, with no output beat.
- New-measurement detect, every cycle: new = (count_in != count_prev) && (count_in != 0). count_prev <= count_in on every edge. count_in == 0 never triggers (divide-by-zero guard). Repeated identical counts produce no new beat.
- States: IDLE, DIV, OUT.
- IDLE: on the edge where new=1, latch divisor=count_in and numerator=CLK_FREQ*Ncycles<<FRAC_BITS, computed in DIV_WIDTH bits with wrap modulo 2^DIV_WIDTH. Then go to DIV and set busy=1.
- DIV: exactly DIV_WIDTH iterations, MSB-first restoring division: shift remainder, compare, subtract, set quotient bit. After the last iteration the next edge loads the outputs and moves to OUT.
- OUT: tvalid=1 and tdata held stable until an edge with tready=1. Then tvalid=0 and the block goes to IDLE, or directly to DIV if a measurement is pending.
- Latency: if count_in first shows a new value in cycle N (latched at edge N), tvalid is high from cycle N+DIV_WIDTH+1, i.e. 65 cycles with defaults. tvalid may not rise earlier.
- Output width rule: if quotient >= 2^AXIS_TDATA_WIDTH, tdata=all ones and saturated=1. Otherwise tdata=quotient[AXIS_TDATA_WIDTH-1:0] and saturated=0. The quotient is truncated, never rounded.
- Measurements arriving while busy: latch count_in/Ncycles into a single pending slot and set pending=1. A further arrival overwrites the slot (newest wins) with no error flag. The pending slot is consumed on the OUT handshake edge, with operands latched on that edge.
- new=1 on the same edge as the OUT handshake: the new value goes directly to the operand registers, superseding any pending slot, and the block enters DIV.
- Ncycles is sampled only at operand latch. Ncycles=0 gives quotient 0, which is emitted normally.
- AXIS rule: once tvalid is high, tdata and saturated stay unchanged until handshake.

Test Plan:
- Defaults; Ncycles=1, count_in 0→125000 → one beat: tdata=1000, saturated=0, tvalid first high exactly 65 cycles after count_in change.
- Ncycles=10, count_in=1250000 → tdata=1000. Then count_in=3 with Ncycles=1 → tdata=41666666 (truncated).
- FRAC_BITS=8, Ncycles=1, count_in=125000 → tdata=256000. Then count_in=1, Ncycles=100 → tdata=0xFFFFFFFF, saturated=1.
- tready held low 200 cycles while count_in steps 125000→62500→25000 → first beat 1000 held stable the whole time. After tready=1, exactly one more beat, 5000; the 2000 measurement is dropped.
- count_in toggles to 0, then is held at 125000 for 500 cycles → exactly one beat. rst pulsed at iteration 30 of a division → no beat, tvalid=0, busy=0; the same count_in reappears as new after reset and yields 1000.
